serial_adder_ctrl: RTL and testbench

- Bit-serial N-bit adder controller: latches two WIDTH-bit operands and a carry-in on a start request.
- Sequences a single full-adder cell (two half adders plus an OR) over the operands, LSB first, one bit per clock.
- Presents the registered Sum/Carry result with a busy/done handshake.
- Serves as the shared-adder sequencer for area-constrained arithmetic paths.

---
 rtl/serial_adder_ctrl.sv | 90 +++++++++
 tb/tb_serial_adder_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell is stepped over latched
// operands LSB first, and the registered sum/carry is handed back with busy/done.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; operands are latched on an accepted start
// RUN   | one result bit per cycle, LSB first
// DONE  | result valid, done pulse; a held start restarts immediately
module serial_adder_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr, b_sr, r_sr, sum_q;
  logic               c_q, carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               hs1, hc1, hc2, s_bit, c_next, last_bit, accept;

  // full adder built from two half adders and an OR
  assign hs1      = a_sr[0] ^ b_sr[0];
  assign hc1      = a_sr[0] & b_sr[0];
  assign s_bit    = hs1 ^ c_q;
  assign hc2      = hs1 & c_q;
  assign c_next   = hc1 | hc2;
  assign last_bit = (cnt_q == CNT_W'(WIDTH-1));
  assign accept   = start && (state_q == IDLE || state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      r_sr    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      a_sr  <= A;
      b_sr  <= B;
      c_q   <= Cin;
      r_sr  <= '0;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      r_sr  <= {s_bit, r_sr[WIDTH-1:1]};
      c_q   <= c_next;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_bit) begin
        sum_q   <= {s_bit, r_sr[WIDTH-1:1]};
        carry_q <= c_next;
      end
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign Sum   = sum_q;
  assign Carry = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8): vector table plus hand-written
// sequences for ignored start, result hold, back-to-back and async reset.
module tb_serial_adder_ctrl;

  logic       clk, rst_n, start, Cin;
  logic [7:0] A, B;
  logic       busy, done, Carry;
  logic [7:0] Sum;

  int errors = 0;
  int checks = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .Sum(Sum), .Carry(Carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       carry;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  // mode 1 pokes start and operands mid-run; mode 2 checks the old result holds.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] es, input logic ec, input int mode,
                        input logic [7:0] ps, input logic pc);
    A = a; B = b; Cin = cin; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
      if (mode == 1 && i == 3) begin A = 8'hFF; B = 8'hFF; Cin = 1'b1; start = 1'b1; end
      if (mode == 1 && i == 4) start = 1'b0;
      if (mode == 2) begin
        chk("sum_hold", Sum, ps);
        chk("carry_hold", Carry, pc);
      end
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 0);
    chk("sum", Sum, es);
    chk("carry", Carry, ec);
    @(negedge clk);
    chk("done_fall", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    int last, np, guard;
    vecs[0] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[7] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0};
    vecs[8] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1};
    vecs[9] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", Sum, 0);
    chk("rst_carry", Carry, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 10; v++)
      run_op(vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].sum, vecs[v].carry, 0, 8'h00, 1'b0);

    // async reset at counter==4, between edges; previous result is FF/1
    A = 8'hC3; B = 8'h11; Cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_sum", Sum, 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_sum", Sum, 0);
    chk("async_carry", Carry, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 0, 8'h00, 1'b0);

    // start and operand changes during RUN are ignored
    run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1, 8'h00, 1'b0);
    @(negedge clk);
    chk("no_second_op", busy | done, 0);

    // previous result holds through a whole second operation
    run_op(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 0, 8'h00, 1'b0);
    run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 2, 8'h7E, 1'b0);

    // start held high: done every 9 cycles, busy low only in DONE
    A = 8'h03; B = 8'h04; Cin = 1'b0; start = 1'b1;
    last = -1; np = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("busy_xor_done", busy ^ done, 1);
      if (done) begin
        if (last >= 0) chk("done_period", i - last, 9);
        chk("held_sum", Sum, 8'h07);
        last = i;
        np++;
      end
    end
    chk("done_count", np, 4);
    start = 1'b0;
    guard = 0;
    while ((busy || done) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_idle", busy | done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
